// File: rtl/fb_scanout_pkg.sv
// Shared types and colour helpers for the framebuffer stream scanout.
// Used by fb_stream_scanout and fb_line_buffer.
package fb_scanout_pkg;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } argb4444_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int NUM_BARS = 8;

  // Nibble replication maps 4'hF to 8'hFF exactly; alpha is not used by the encoder.
  function automatic rgb888_t argb4444_to_rgb888(input argb4444_t px);
    rgb888_t c;
    c.r = {px.r, px.r};
    c.g = {px.g, px.g};
    c.b = {px.b, px.b};
    return c;
  endfunction

  function automatic rgb888_t bar_colour(input logic [2:0] idx);
    rgb888_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// One framebuffer line of ARGB4444 words: simple dual-port RAM,
// synchronous write and registered read on clk_pix.
module fb_line_buffer
  import fb_scanout_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 16,
  parameter int AW     = 7
) (
  input  logic              clk_pix,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_pix) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_stream_scanout.sv
// Framebuffer stream consumer: paces stream_ena_o from display timing, scales by SCALE
// with pixel repeat plus a line buffer. Optional colour bars via FB_SCANOUT_TEST_PATTERN_EN.
module fb_stream_scanout
  import fb_scanout_pkg::*;
#(
  parameter int          FB_WIDTH   = 128,
  parameter int          FB_HEIGHT  = 128,
  parameter int          SCALE      = 4,
  parameter int          HPOS_W     = 10,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk_pix,
  input  logic              reset_n_i,
  input  logic [HPOS_W-1:0] hpos_i,
  input  logic [HPOS_W-1:0] vpos_i,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              frame_start_i,
  input  logic [23:0]       base_address_i,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic              test_pattern_i,
`endif
  output logic              stream_start_frame_o,
  output logic [23:0]       stream_base_address_o,
  output logic              stream_ena_o,
  input  logic [15:0]       stream_data_i,
  input  logic              stream_err_underflow_i,
  input  logic              err_clear_i,
  output logic              err_underflow_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [7:0]        r_o,
  output logic [7:0]        g_o,
  output logic [7:0]        b_o
);

  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int YW = $clog2(FB_HEIGHT + 1);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HPOS_W:0] IMG_W    = (HPOS_W+1)'(FB_WIDTH * SCALE);
  localparam logic [HPOS_W:0] IMG_H    = (HPOS_W+1)'(FB_HEIGHT * SCALE);
  localparam logic [SW-1:0]   LAST_SUB = SW'(SCALE - 1);
  localparam logic [XW-1:0]   LAST_X   = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]   ROWS     = YW'(FB_HEIGHT);

  logic          armed;
  logic [SW-1:0] sub_px;
  logic [SW-1:0] sub_line;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;

  logic win_p0, fetch_line_p0, ena_p0;

  logic          vld_p1, ena_p1, fetch_p1, de_p1, hs_p1, vs_p1;
  logic [XW-1:0] fb_x_p1;
  logic [15:0]   lb_rdata_p1;
  logic [15:0]   hold_word;
  logic [15:0]   px_p1;
  rgb888_t       colour_p1;

  rgb888_t rgb_p2;
  logic    de_p2, hs_p2, vs_p2;

  // ---- stage p0: window decode, fetch request, position counters ----
  assign win_p0        = de_i && ({1'b0, hpos_i} < IMG_W) && ({1'b0, vpos_i} < IMG_H);
  assign fetch_line_p0 = (sub_line == '0);
  // The fb_y guard keeps the pulse count at FB_WIDTH*FB_HEIGHT even if vblank comes late.
  assign ena_p0        = armed && win_p0 && fetch_line_p0 && (sub_px == '0) && (fb_y < ROWS);
  assign stream_ena_o  = ena_p0;

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      armed                 <= 1'b0;
      sub_px                <= '0;
      sub_line              <= '0;
      fb_x                  <= '0;
      fb_y                  <= '0;
      stream_start_frame_o  <= 1'b0;
      stream_base_address_o <= '0;
    end else begin
      stream_start_frame_o <= frame_start_i;
      if (frame_start_i) begin
        armed                 <= 1'b1;
        stream_base_address_o <= base_address_i;
        sub_px                <= '0;
        sub_line              <= '0;
        fb_x                  <= '0;
        fb_y                  <= '0;
      end else if (win_p0) begin
        if (sub_px == LAST_SUB) begin
          sub_px <= '0;
          if (fb_x != LAST_X) fb_x <= fb_x + 1'b1;
        end else begin
          sub_px <= sub_px + 1'b1;
        end
      end else if (vld_p1) begin
        sub_px <= '0;
        fb_x   <= '0;
        if (sub_line == LAST_SUB) begin
          sub_line <= '0;
          if (fb_y != ROWS) fb_y <= fb_y + 1'b1;
        end else begin
          sub_line <= sub_line + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: stream word arrives / line buffer read data ----
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p1   <= 1'b0;
      ena_p1   <= 1'b0;
      fetch_p1 <= 1'b0;
      de_p1    <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
    end else begin
      vld_p1   <= win_p0;
      ena_p1   <= ena_p0;
      fetch_p1 <= fetch_line_p0;
      de_p1    <= de_i;
      hs_p1    <= hsync_i;
      vs_p1    <= vsync_i;
    end
  end

  always_ff @(posedge clk_pix) begin
    fb_x_p1 <= fb_x;
    if (ena_p1) hold_word <= stream_data_i;
  end

  fb_line_buffer #(
    .DEPTH  (FB_WIDTH),
    .DATA_W (16),
    .AW     (XW)
  ) u_line_buffer (
    .clk_pix (clk_pix),
    .we      (ena_p1),
    .waddr   (fb_x_p1),
    .wdata   (stream_data_i),
    .raddr   (fb_x),
    .rdata   (lb_rdata_p1)
  );

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic [2:0] bar_p0;
  logic [2:0] bar_p1;
  logic       tp_p1;

  assign bar_p0 = 3'((32'(hpos_i) * NUM_BARS) / (FB_WIDTH * SCALE));

  always_ff @(posedge clk_pix) begin
    bar_p1 <= bar_p0;
    tp_p1  <= test_pattern_i;
  end
`endif

  always_comb begin
    px_p1 = lb_rdata_p1;
    if (fetch_p1) px_p1 = ena_p1 ? stream_data_i : hold_word;
    colour_p1 = argb4444_to_rgb888(argb4444_t'(px_p1));
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    if (tp_p1) colour_p1 = bar_colour(bar_p1);
`endif
  end

  // ---- stage p2: colour and timing registers to the encoder ----
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rgb_p2 <= '0;
      de_p2  <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      rgb_p2 <= vld_p1 ? colour_p1 : rgb888_t'(BORDER_RGB);
      de_p2  <= de_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i)                  err_underflow_o <= 1'b0;
    else if (stream_err_underflow_i) err_underflow_o <= 1'b1;
    else if (err_clear_i)            err_underflow_o <= 1'b0;
  end

  assign r_o     = rgb_p2.r;
  assign g_o     = rgb_p2.g;
  assign b_o     = rgb_p2.b;
  assign de_o    = de_p2;
  assign hsync_o = hs_p2;
  assign vsync_o = vs_p2;

endmodule

// File: tb/tb_fb_stream_scanout.sv
// Bench for fb_stream_scanout: 32x4 framebuffer at SCALE 2 on an 80x10 visible display,
// framebuffer responder plus coordinate-based reference model.
module tb_fb_stream_scanout;

  localparam int FB_W  = 32;
  localparam int FB_H  = 4;
  localparam int SC    = 2;
  localparam int HW    = 10;
  localparam logic [23:0] BORDER = 24'h102030;
  localparam int H_ACT = 80;
  localparam int H_TOT = 100;
  localparam int V_ACT = 10;
  localparam int V_TOT = 14;
  localparam int IMG_W = FB_W * SC;
  localparam int IMG_H = FB_H * SC;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic          reset_n_i;
  logic [HW-1:0] hpos_i, vpos_i;
  logic          de_i, hsync_i, vsync_i, frame_start_i;
  logic [23:0]   base_address_i;
  logic          stream_start_frame_o;
  logic [23:0]   stream_base_address_o;
  logic          stream_ena_o;
  logic [15:0]   stream_data_i;
  logic          stream_err_underflow_i, err_clear_i, err_underflow_o;
  logic          de_o, hsync_o, vsync_o;
  logic [7:0]    r_o, g_o, b_o;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic          test_pattern_i = 1'b0;
`endif

  fb_stream_scanout #(
    .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .SCALE(SC), .HPOS_W(HW), .BORDER_RGB(BORDER)
  ) dut (
    .clk_pix(clk_pix), .reset_n_i(reset_n_i),
    .hpos_i(hpos_i), .vpos_i(vpos_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .frame_start_i(frame_start_i), .base_address_i(base_address_i),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .test_pattern_i(test_pattern_i),
`endif
    .stream_start_frame_o(stream_start_frame_o), .stream_base_address_o(stream_base_address_o),
    .stream_ena_o(stream_ena_o), .stream_data_i(stream_data_i),
    .stream_err_underflow_i(stream_err_underflow_i), .err_clear_i(err_clear_i),
    .err_underflow_o(err_underflow_o),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  typedef struct {
    bit          de, hs, vs, chk;
    logic [23:0] rgb;
    int          h, v;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  r, g, b;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [FB_W*FB_H];
  int          ptr;
  bit          pend;
  bit          armed;
  int          origin;
  bit          start_exp;
  logic [23:0] base_exp;
  bit          err_exp;
  int          ena_cnt;
  exp_t        h1, h2;
  logic [23:0] cap0 [IMG_W];
  logic [23:0] cap1 [IMG_W];
  vec_t        vec [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] rgb_of(input logic [15:0] w);
    int r, g, b;
    r = ((int'(w) >> 8) & 15) * 17;
    g = ((int'(w) >> 4) & 15) * 17;
    b = (int'(w) & 15) * 17;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e.de = 0; e.hs = 0; e.vs = 0; e.chk = 1; e.rgb = BORDER; e.h = -1; e.v = -1;
    return e;
  endfunction

  // One display cycle; entered and left just after a rising edge.
  task automatic cycle(input int h, input int v, input bit fs, input logic [23:0] base,
                       input bit rst_mid);
    exp_t cur;
    bit   win, exp_ena, img;
    int   y;
    de_i           = (h < H_ACT) && (v < V_ACT);
    hsync_i        = (h >= 85) && (h < 95);
    vsync_i        = (v >= 11) && (v < 13);
    hpos_i         = HW'(h);
    vpos_i         = HW'(v);
    frame_start_i  = fs;
    base_address_i = base;
    if (pend) begin
      stream_data_i = mem[ptr % (FB_W*FB_H)];
      ptr++;
    end else begin
      stream_data_i = 16'($urandom);
    end

    win = de_i && (h < IMG_W) && (v < IMG_H);
    y   = (v - origin) / SC;
    img = armed && (v >= origin) && (y < FB_H);
    exp_ena = win && img && (h % SC == 0) && ((v - origin) % SC == 0);
    cur.de = de_i; cur.hs = hsync_i; cur.vs = vsync_i; cur.h = h; cur.v = v;
    cur.chk = !win || img;
    cur.rgb = (win && img) ? rgb_of(mem[y*FB_W + h/SC]) : BORDER;

    if (rst_mid) begin
      #2 reset_n_i = 1'b0;
      #1;
      chk("reset_rgb", {8'h0, r_o, g_o, b_o}, 32'h0);
      chk("reset_ctl", {de_o, hsync_o, vsync_o, stream_ena_o, stream_start_frame_o, err_underflow_o}, 0);
      chk("reset_base", stream_base_address_o, 0);
      armed = 0; start_exp = 0; base_exp = 0; err_exp = 0;
      cur.chk = !win;
      h1 = idle_e();
      @(negedge clk_pix);
      reset_n_i = 1'b1;
      pend = 0;
    end else begin
      @(negedge clk_pix);
      chk("stream_ena", stream_ena_o, exp_ena);
      chk("start_frame", stream_start_frame_o, start_exp);
      chk("base_addr", stream_base_address_o, base_exp);
      chk("err_flag", err_underflow_o, err_exp);
      chk("timing_delay", {de_o, hsync_o, vsync_o}, {h2.de, h2.hs, h2.vs});
      if (h2.chk) chk("pixel", {r_o, g_o, b_o}, h2.rgb);
      if (h2.v == 0 && h2.h >= 0 && h2.h < IMG_W) cap0[h2.h] = {r_o, g_o, b_o};
      if (h2.v == 1 && h2.h >= 0 && h2.h < IMG_W) cap1[h2.h] = {r_o, g_o, b_o};
      if (stream_start_frame_o) ptr = 0;
      pend = stream_ena_o;
      if (stream_ena_o) ena_cnt++;
      start_exp = fs;
      if (fs) begin
        armed    = 1;
        base_exp = base;
        origin   = (v >= V_ACT) ? 0 : v + 1;
      end
    end
    h2 = h1;
    h1 = cur;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic run_vblank();
    logic [23:0] b;
    b = 24'($urandom);
    for (int v = V_ACT; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++)
        cycle(h, v, (v == V_ACT && h == 0), b, 1'b0);
  endtask

  task automatic run_frame(input int fs_mid_v, input int rst_v, input bit use_table);
    logic [23:0] mid_b, vb_b;
    bit          fs;
    mid_b = 24'($urandom);
    vb_b  = 24'($urandom);
    for (int i = 0; i < FB_W*FB_H; i++) mem[i] = 16'($urandom);
    if (use_table) for (int i = 0; i < 6; i++) mem[i] = vec[i].word;
    ena_cnt = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        fs = (v == V_ACT && h == 0) || (v == fs_mid_v && h == H_TOT - 1);
        cycle(h, v, fs, (v == V_ACT) ? vb_b : mid_b, (v == rst_v && h == 20));
        if (v == V_ACT - 1 && h == H_TOT - 1 && fs_mid_v < 0 && rst_v < 0)
          chk("ena_per_frame", ena_cnt, FB_W*FB_H);
      end
    end
  endtask

  initial begin
    vec[0] = '{16'hF0A5, 8'h00, 8'hAA, 8'h55};
    vec[1] = '{16'h0FFF, 8'hFF, 8'hFF, 8'hFF};
    vec[2] = '{16'h1234, 8'h22, 8'h33, 8'h44};
    vec[3] = '{16'h8000, 8'h00, 8'h00, 8'h00};
    vec[4] = '{16'h0C3E, 8'hCC, 8'h33, 8'hEE};
    vec[5] = '{16'hF9B1, 8'h99, 8'hBB, 8'h11};

    reset_n_i = 1'b0;
    hpos_i = '0; vpos_i = '0; de_i = 0; hsync_i = 0; vsync_i = 0; frame_start_i = 0;
    base_address_i = '0; stream_data_i = '0; stream_err_underflow_i = 0; err_clear_i = 0;
    ptr = 0; pend = 0; armed = 0; origin = 0; start_exp = 0; base_exp = 0; err_exp = 0;
    ena_cnt = 0;
    h1 = idle_e(); h2 = idle_e();

    repeat (3) @(posedge clk_pix);
    #1;
    chk("reset_rgb_init", {8'h0, r_o, g_o, b_o}, 32'h0);
    chk("reset_ctl_init", {de_o, hsync_o, vsync_o, stream_ena_o, stream_start_frame_o, err_underflow_o}, 0);
    chk("reset_base_init", stream_base_address_o, 0);
    @(negedge clk_pix);
    reset_n_i = 1'b1;
    @(posedge clk_pix);
    #1;

    // Idle lines before any frame_start: must not fetch.
    for (int h = 0; h < H_TOT; h++) cycle(h, 0, 1'b0, 24'h0, 1'b0);
    run_vblank();

    run_frame(-1, -1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("table_l0_a", cap0[2*i],     {vec[i].r, vec[i].g, vec[i].b});
      chk("table_l0_b", cap0[2*i + 1], {vec[i].r, vec[i].g, vec[i].b});
      chk("table_l1_a", cap1[2*i],     {vec[i].r, vec[i].g, vec[i].b});
      chk("table_l1_b", cap1[2*i + 1], {vec[i].r, vec[i].g, vec[i].b});
    end

    run_frame(-1, -1, 1'b0);
    run_frame(5, -1, 1'b0);
    run_frame(-1, -1, 1'b0);
    run_frame(-1, 3, 1'b0);
    run_frame(-1, -1, 1'b0);

    // Underflow flag: set beats clear, then sticky, then clear alone.
    de_i = 0; frame_start_i = 0;
    stream_err_underflow_i = 1; err_clear_i = 1;
    @(posedge clk_pix); #1;
    stream_err_underflow_i = 0; err_clear_i = 0;
    chk("err_set_wins", err_underflow_o, 1);
    repeat (3) @(posedge clk_pix);
    #1;
    chk("err_sticky", err_underflow_o, 1);
    err_clear_i = 1;
    @(posedge clk_pix); #1;
    err_clear_i = 0;
    chk("err_cleared", err_underflow_o, 0);
    stream_err_underflow_i = 1;
    @(posedge clk_pix); #1;
    stream_err_underflow_i = 0;
    chk("err_set_again", err_underflow_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
